// File: rtl/oled_ctrl_seq.sv
// oled_ctrl_seq: SSD1306 power-up sequencer and byte-stream forwarder in front of the SPI serializer.
// Latency: an accepted stream byte appears on spi_data/spi_send the next cycle.
// Backpressure: s_ready is low while a byte is in flight; a serializer holding spi_rdy stalls the FSM indefinitely.
// Optional feature: define OLED_PWRDOWN_EN to add the stop input and the orderly power-down sequence.
module oled_ctrl_seq #(
  parameter int unsigned DLY_VDD  = 100000,
  parameter int unsigned DLY_RES  = 1000,
  parameter int unsigned DLY_VBAT = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef OLED_PWRDOWN_EN
  input  logic       stop,
`endif
  output logic       init_done,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_dc,
  output logic       s_ready,
  output logic       spi_en,
  output logic [7:0] spi_data,
  output logic       spi_send,
  input  logic       spi_rdy,
  output logic       oled_dc,
  output logic       oled_res_n,
  output logic       oled_vdd_n,
  output logic       oled_vbat_n
);

  typedef enum logic [3:0] {
    ST_OFF,
    ST_VDD,
    ST_RES_LO,
    ST_RES_HI,
    ST_PRE,
    ST_VBAT,
    ST_POST,
    ST_IDLE,
    ST_XFER,
    ST_PD_CMD,
    ST_PD_VBAT
  } state_t;

  // Byte handshake phase: REQ waits for the serializer to go busy, ACK waits for it to finish.
  typedef enum logic [1:0] {
    XF_IDLE,
    XF_REQ,
    XF_ACK
  } xfer_t;

  state_t      state;
  xfer_t       xfer;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        ready_q;
  logic        init_q;
  logic        byte_done;
  logic        cnt_zero;

  assign byte_done = (xfer == XF_ACK) && spi_rdy;
  assign cnt_zero  = (cnt == 32'd0);

  // Counter reload value: the wait ends when the counter reaches zero, so N cycles needs N-1.
  function automatic logic [31:0] dly_load(input int unsigned n);
    return (n == 0) ? 32'd0 : 32'(n - 1);
  endfunction

  // Init command ROM: first five bytes go before VBAT, last five after.
  function automatic logic [7:0] rom_byte(input logic post, input logic [2:0] i);
    logic [7:0] b;
    b = 8'h00;
    case ({post, i})
      4'b0_000: b = 8'hAE;  // display off
      4'b0_001: b = 8'h8D;  // charge pump setting
      4'b0_010: b = 8'h14;  // charge pump on
      4'b0_011: b = 8'hD9;  // pre-charge period
      4'b0_100: b = 8'hF1;
      4'b1_000: b = 8'hA1;  // segment remap
      4'b1_001: b = 8'hC8;  // COM scan direction
      4'b1_010: b = 8'hDA;  // COM pins config
      4'b1_011: b = 8'h02;
      4'b1_100: b = 8'hAF;  // display on
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef OLED_PWRDOWN_EN
  // stop wins over s_valid in the same cycle, so ready and init_done drop combinationally.
  assign s_ready   = ready_q & ~stop;
  assign init_done = init_q & ~(stop & ready_q);
`else
  assign s_ready   = ready_q;
  assign init_done = init_q;
`endif

  // Main sequencer: power rails, reset pulse, ROM bytes, stream forwarding, with the byte handshake folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      xfer        <= XF_IDLE;
      cnt         <= 32'd0;
      idx         <= 3'd0;
      ready_q     <= 1'b0;
      init_q      <= 1'b0;
      spi_en      <= 1'b0;
      spi_data    <= 8'h00;
      spi_send    <= 1'b0;
      oled_dc     <= 1'b0;
      oled_res_n  <= 1'b1;
      oled_vdd_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
    end else begin
      if (!cnt_zero) cnt <= cnt - 32'd1;
      if ((xfer == XF_REQ) && !spi_rdy) begin
        xfer     <= XF_ACK;
        spi_send <= 1'b0;
      end
      if (byte_done) xfer <= XF_IDLE;

      case (state)
        ST_OFF: begin
          if (start) begin
            state      <= ST_VDD;
            oled_vdd_n <= 1'b0;
            spi_en     <= 1'b1;
            cnt        <= dly_load(DLY_VDD);
          end
        end
        ST_VDD: begin
          if (cnt_zero) begin
            state      <= ST_RES_LO;
            oled_res_n <= 1'b0;
            cnt        <= dly_load(DLY_RES);
          end
        end
        ST_RES_LO: begin
          if (cnt_zero) begin
            state      <= ST_RES_HI;
            oled_res_n <= 1'b1;
            cnt        <= dly_load(DLY_RES);
          end
        end
        ST_RES_HI: begin
          if (cnt_zero) begin
            state    <= ST_PRE;
            idx      <= 3'd0;
            spi_data <= rom_byte(1'b0, 3'd0);
            oled_dc  <= 1'b0;
            spi_send <= 1'b1;
            xfer     <= XF_REQ;
          end
        end
        ST_PRE: begin
          if (byte_done) begin
            if (idx == 3'd4) begin
              state       <= ST_VBAT;
              oled_vbat_n <= 1'b0;
              cnt         <= dly_load(DLY_VBAT);
            end else begin
              idx      <= idx + 3'd1;
              spi_data <= rom_byte(1'b0, idx + 3'd1);
              spi_send <= 1'b1;
              xfer     <= XF_REQ;
            end
          end
        end
        ST_VBAT: begin
          if (cnt_zero) begin
            state    <= ST_POST;
            idx      <= 3'd0;
            spi_data <= rom_byte(1'b1, 3'd0);
            oled_dc  <= 1'b0;
            spi_send <= 1'b1;
            xfer     <= XF_REQ;
          end
        end
        ST_POST: begin
          if (byte_done) begin
            if (idx == 3'd4) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
              init_q  <= 1'b1;
            end else begin
              idx      <= idx + 3'd1;
              spi_data <= rom_byte(1'b1, idx + 3'd1);
              spi_send <= 1'b1;
              xfer     <= XF_REQ;
            end
          end
        end
        ST_IDLE: begin
`ifdef OLED_PWRDOWN_EN
          if (stop) begin
            state    <= ST_PD_CMD;
            ready_q  <= 1'b0;
            init_q   <= 1'b0;
            spi_data <= 8'hAE;
            oled_dc  <= 1'b0;
            spi_send <= 1'b1;
            xfer     <= XF_REQ;
          end else
`endif
          if (s_valid) begin
            state    <= ST_XFER;
            ready_q  <= 1'b0;
            spi_data <= s_data;
            oled_dc  <= s_dc;
            spi_send <= 1'b1;
            xfer     <= XF_REQ;
          end
        end
        ST_XFER: begin
          if (byte_done) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
`ifdef OLED_PWRDOWN_EN
        ST_PD_CMD: begin
          if (byte_done) begin
            state       <= ST_PD_VBAT;
            oled_vbat_n <= 1'b1;
            cnt         <= dly_load(DLY_VBAT);
          end
        end
        ST_PD_VBAT: begin
          if (cnt_zero) begin
            state      <= ST_OFF;
            oled_vdd_n <= 1'b1;
            spi_en     <= 1'b0;
            spi_data   <= 8'h00;
          end
        end
`endif
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_ctrl_seq.sv
// tb_oled_ctrl_seq: directed bench for oled_ctrl_seq with a behavioural SPI serializer.
// Checks reset values, power-up ordering and timing, stream forwarding, data stability and mid-sequence reset.
// Power-down sequence is exercised when OLED_PWRDOWN_EN is defined.
module tb_oled_ctrl_seq;

  localparam int DLY_VDD  = 10;
  localparam int DLY_RES  = 4;
  localparam int DLY_VBAT = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_dc = 1'b0;
  logic       init_done, s_ready, spi_en, spi_send, oled_dc;
  logic       oled_res_n, oled_vdd_n, oled_vbat_n;
  logic [7:0] spi_data;
  logic       spi_rdy;
`ifdef OLED_PWRDOWN_EN
  logic       stop = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  oled_ctrl_seq #(
    .DLY_VDD (DLY_VDD),
    .DLY_RES (DLY_RES),
    .DLY_VBAT(DLY_VBAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef OLED_PWRDOWN_EN
    .stop       (stop),
`endif
    .init_done  (init_done),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_dc       (s_dc),
    .s_ready    (s_ready),
    .spi_en     (spi_en),
    .spi_data   (spi_data),
    .spi_send   (spi_send),
    .spi_rdy    (spi_rdy),
    .oled_dc    (oled_dc),
    .oled_res_n (oled_res_n),
    .oled_vdd_n (oled_vdd_n),
    .oled_vbat_n(oled_vbat_n)
  );

  // Serializer model: accepts a byte when idle and send is high, stays busy for a fixed or random latency.
  int         cyc = 0;
  logic       ser_busy;
  int         ser_cnt;
  logic       ser_rand = 1'b0;
  logic [8:0] cur_byte;
  logic [8:0] log_q[$];
  int         log_cyc[$];

  assign spi_rdy = ~ser_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_busy <= 1'b0;
      ser_cnt  <= 0;
    end else if (!ser_busy && spi_send) begin
      ser_busy <= 1'b1;
      ser_cnt  <= ser_rand ? int'($urandom_range(20, 1)) : 2;
      cur_byte <= {oled_dc, spi_data};
      log_q.push_back({oled_dc, spi_data});
      log_cyc.push_back(cyc);
    end else if (ser_busy) begin
      if (ser_cnt <= 1) ser_busy <= 1'b0;
      else ser_cnt <= ser_cnt - 1;
    end
  end

  // Monitor: byte stability while the serializer is busy, s_ready low during transfers, pin edge times.
  int   stab_err = 0;
  int   rdy_err = 0;
  int   t_vdd_fall = -1, t_vdd_rise = -1, t_res_fall = -1, t_res_rise = -1;
  int   t_vbat_fall = -1, t_vbat_rise = -1;
  logic p_vdd = 1'b1, p_res = 1'b1, p_vbat = 1'b1;

  always @(negedge clk) begin
    if (rst_n && ser_busy && ({oled_dc, spi_data} !== cur_byte)) stab_err++;
    if (rst_n && (ser_busy || spi_send) && s_ready) rdy_err++;
    if (p_vdd && !oled_vdd_n) t_vdd_fall = cyc;
    if (!p_vdd && oled_vdd_n) t_vdd_rise = cyc;
    if (p_res && !oled_res_n) t_res_fall = cyc;
    if (!p_res && oled_res_n) t_res_rise = cyc;
    if (p_vbat && !oled_vbat_n) t_vbat_fall = cyc;
    if (!p_vbat && oled_vbat_n) t_vbat_rise = cyc;
    p_vdd  = oled_vdd_n;
    p_res  = oled_res_n;
    p_vbat = oled_vbat_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100000;
  endfunction

  function automatic bit cond(input int sel, input int n);
    case (sel)
      0:       return init_done === 1'b1;
      1:       return s_ready === 1'b1;
      2:       return log_q.size() >= n;
      default: return oled_vdd_n === 1'b1;
    endcase
  endfunction

  // Bounded wait at negedges for a DUT condition; an expired bound is a failed comparison.
  task automatic wait_for(input int sel, input int n, input string name);
    int k;
    bit hit;
    k = 0;
    hit = cond(sel, n);
    while (!hit && k < 5000) begin
      @(negedge clk);
      k++;
      hit = cond(sel, n);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: got timeout after %0d cycles, expected condition reached", name, k);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vdd_n"},     32'(oled_vdd_n),  32'd1);
    check({tag, "_vbat_n"},    32'(oled_vbat_n), 32'd1);
    check({tag, "_res_n"},     32'(oled_res_n),  32'd1);
    check({tag, "_dc"},        32'(oled_dc),     32'd0);
    check({tag, "_spi_en"},    32'(spi_en),      32'd0);
    check({tag, "_spi_send"},  32'(spi_send),    32'd0);
    check({tag, "_spi_data"},  32'(spi_data),    32'd0);
    check({tag, "_s_ready"},   32'(s_ready),     32'd0);
    check({tag, "_init_done"}, 32'(init_done),   32'd0);
  endtask

  logic [8:0] exp_init[10] = '{9'h0AE, 9'h08D, 9'h014, 9'h0D9, 9'h0F1,
                               9'h0A1, 9'h0C8, 9'h0DA, 9'h002, 9'h0AF};

  // Byte order, dc and rail/reset timing of one power-up whose first byte is log entry base.
  task automatic check_powerup(input string tag, input int base);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_byte%0d", tag, i), log_at(base + i), 32'(exp_init[i]));
    check({tag, "_byte_count"}, 32'(log_q.size()), 32'(base + 10));
    check_range({tag, "_vdd_to_res"}, t_res_fall - t_vdd_fall, DLY_VDD - 1, DLY_VDD + 1);
    check_range({tag, "_res_low"}, t_res_rise - t_res_fall, DLY_RES - 1, DLY_RES + 1);
    check_range({tag, "_res_to_pre"}, cyc_at(base) - t_res_rise, DLY_RES - 1, 100);
    check_range({tag, "_pre_before_vbat"}, t_vbat_fall - cyc_at(base + 4), 1, 100);
    check_range({tag, "_vbat_wait"}, cyc_at(base + 5) - t_vbat_fall, DLY_VBAT, DLY_VBAT + 100);
    check({tag, "_spi_en"}, 32'(spi_en), 32'd1);
    check({tag, "_vbat_on"}, 32'(oled_vbat_n), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] exp_byte;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [8:0] exp_q[$];
    int         base;
    int         err;

    vecs[0] = '{8'h55, 1'b1, 9'h155};
    vecs[1] = '{8'h3C, 1'b0, 9'h03C};
    vecs[2] = '{8'hA5, 1'b1, 9'h1A5};
    vecs[3] = '{8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'hFF, 1'b1, 9'h1FF};

    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // No start: pins must not move
    err = 0;
    repeat (100) begin
      @(negedge clk);
      if (oled_vdd_n !== 1'b1 || oled_vbat_n !== 1'b1 || oled_res_n !== 1'b1 || spi_en !== 1'b0 ||
          spi_send !== 1'b0 || s_ready !== 1'b0 || init_done !== 1'b0) err++;
    end
    check("nostart_pins_changed", 32'(err), 32'd0);
    check("nostart_bytes", 32'(log_q.size()), 32'd0);

    // Power-up
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 0, "boot1_init_done");
    check_powerup("boot1", 0);

    // Stream table, back-to-back
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = vecs[i].data;
      s_dc    = vecs[i].dc;
      wait_for(1, 0, $sformatf("stream%0d_ready", i));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stream%0d_ready_low", i), 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    wait_for(2, base + 5, "stream_bytes");
    for (int i = 0; i < 5; i++)
      check($sformatf("stream%0d_byte", i), log_at(base + i), 32'(vecs[i].exp_byte));
    check("stream_b2b_gap", 32'(cyc_at(base + 1) - cyc_at(base)), 32'd5);
    check("stream_init_done", 32'(init_done), 32'd1);

    // Random serializer latency with random bytes
    ser_rand = 1'b1;
    wait_for(1, 0, "rand_idle");
    base = log_q.size();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom_range(255));
      s_dc    = 1'($urandom_range(1));
      exp_q.push_back({s_dc, s_data});
      wait_for(1, 0, $sformatf("rand%0d_ready", i));
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    wait_for(2, base + 8, "rand_bytes");
    for (int i = 0; i < 8; i++)
      check($sformatf("rand%0d_byte", i), log_at(base + i), 32'(exp_q[i]));

    // Reset in the middle of the pre-VBAT commands
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = log_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(2, base + 2, "midpre_two_bytes");
    rst_n = 1'b0;
    #1;
    check_reset("midpre");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = log_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 0, "boot2_init_done");
    check_powerup("boot2", base);

`ifdef OLED_PWRDOWN_EN
    // Power-down with a simultaneous s_valid that must lose to stop
    wait_for(1, 0, "pd_idle");
    base = log_q.size();
    stop    = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    s_dc    = 1'b1;
    #1;
    check("pd_stop_ready", 32'(s_ready), 32'd0);
    check("pd_stop_init", 32'(init_done), 32'd0);
    @(negedge clk);
    stop    = 1'b0;
    s_valid = 1'b0;
    check("pd_init_after", 32'(init_done), 32'd0);
    wait_for(3, 0, "pd_vdd_off");
    check("pd_byte", log_at(base), 32'h0AE);
    check("pd_byte_count", 32'(log_q.size()), 32'(base + 1));
    check_range("pd_vbat_wait", t_vdd_rise - t_vbat_rise, DLY_VBAT - 1, DLY_VBAT + 1);
    check_range("pd_vbat_after_byte", t_vbat_rise - cyc_at(base), 1, 100);
    check("pd_spi_en", 32'(spi_en), 32'd0);
    check("pd_vbat_n", 32'(oled_vbat_n), 32'd1);
    check("pd_init_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);
    base = log_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 0, "boot3_init_done");
    check_powerup("boot3", base);
`endif

    check("data_stability", 32'(stab_err), 32'd0);
    check("ready_low_in_flight", 32'(rdy_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
